// File: rtl/uart_pkg.sv
// uart_pkg: FSM encoding, ASCII constants and baud divider helper shared by the UART blocks.
package uart_pkg;
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
  localparam logic [7:0] ASCII_0 = 8'h30;
  localparam logic [7:0] ASCII_9 = 8'h39;
  localparam logic [7:0] ASCII_CLR_U = 8'h43;
  localparam logic [7:0] ASCII_CLR_L = 8'h63;
  function automatic int baud_div(int clk, int baud, int os);
    return clk / (baud * os);
  endfunction
endpackage

// File: rtl/uart_rx_bcd_if.sv
// uart_rx_bcd_if: serial line in, received byte/strobes/display word out.
interface uart_rx_bcd_if;
  logic        i_rx_data;
  logic [7:0]  o_rx_byte;
  logic        o_rx_valid;
  logic        o_frame_err;
  logic [15:0] o_bcd8d;
  logic        o_led_rx;
  modport master (output i_rx_data, input o_rx_byte, o_rx_valid, o_frame_err, o_bcd8d, o_led_rx);
  modport slave (input i_rx_data, output o_rx_byte, o_rx_valid, o_frame_err, o_bcd8d, o_led_rx);
endinterface

// File: rtl/uart_baud_gen.sv
// uart_baud_gen: free-running 0..DIV-1 divider producing a one-cycle oversample tick.
module uart_baud_gen #(
  parameter int DIV = 10
) (
  input  logic i_clk,
  input  logic i_rstn,
  input  logic i_clr,
  output logic o_tick
);
  localparam int W = $clog2(DIV);
  if (DIV < 2) begin : g_div_chk
    $error("uart_baud_gen: DIV must be >= 2");
  end
  logic [W-1:0] cnt;
  assign o_tick = cnt == W'(DIV - 1);
  always_ff @(posedge i_clk)
    if (!i_rstn || i_clr) cnt <= '0;
    else cnt <= o_tick ? '0 : cnt + 1'b1;
endmodule

// File: rtl/uart_rx_bcd.sv
// uart_rx_bcd: 8N1 receiver at 16x oversampling; ASCII digits shift into a 4-digit BCD display word.
module uart_rx_bcd
  import uart_pkg::*;
#(
  parameter int CLK_FREQ = 50_000_000,
  parameter int BAUD = 9600
) (
  input  logic           i_clk,
  input  logic           i_rstn,
  uart_rx_bcd_if.slave   bus
);
  localparam int DIV = baud_div(CLK_FREQ, BAUD, 16);
  state_t state, state_n;
  logic rx_m, rx_s, tick, clr, smp, ok, err;
  logic [3:0] tick_idx;
  logic [2:0] bit_idx;
  logic [7:0] shreg;
  uart_baud_gen #(.DIV(DIV)) u_baud (
    .i_clk(i_clk), .i_rstn(i_rstn), .i_clr(clr), .o_tick(tick)
  );
  always_ff @(posedge i_clk)
    if (!i_rstn) state <= IDLE;
    else state <= state_n;
  // Start bit checked at tick 7 (mid-bit); later bits every 16 ticks, i.e. when tick_idx wraps at 15.
  always_comb begin
    state_n = state;
    clr = 1'b0;
    smp = 1'b0;
    ok = 1'b0;
    err = 1'b0;
    case (state)
      IDLE: begin
        clr = !rx_s;
        state_n = rx_s ? IDLE : START;
      end
      START: state_n = (tick && tick_idx == 4'd7) ? (rx_s ? IDLE : DATA) : START;
      DATA: begin
        smp = tick && tick_idx == 4'd15;
        state_n = (smp && bit_idx == 3'd7) ? STOP : DATA;
      end
      STOP: if (tick && tick_idx == 4'd15) begin
        state_n = IDLE;
        ok = rx_s;
        err = !rx_s;
      end
    endcase
  end
  always_ff @(posedge i_clk)
    if (!i_rstn) begin
      rx_m <= 1'b1;
      rx_s <= 1'b1;
      tick_idx <= '0;
      bit_idx <= '0;
      shreg <= '0;
      bus.o_rx_byte <= '0;
      bus.o_rx_valid <= 1'b0;
      bus.o_frame_err <= 1'b0;
      bus.o_bcd8d <= '0;
      bus.o_led_rx <= 1'b0;
    end else begin
      rx_m <= bus.i_rx_data;
      rx_s <= rx_m;
      tick_idx <= (clr || (state == START && state_n == DATA)) ? 4'd0 : tick ? tick_idx + 4'd1 : tick_idx;
      bit_idx <= clr ? 3'd0 : smp ? bit_idx + 3'd1 : bit_idx;
      shreg <= smp ? {rx_s, shreg[7:1]} : shreg;
      bus.o_rx_byte <= ok ? shreg : bus.o_rx_byte;
      bus.o_rx_valid <= ok;
      bus.o_frame_err <= err;
      bus.o_led_rx <= state != IDLE;
      if (ok && shreg >= ASCII_0 && shreg <= ASCII_9) bus.o_bcd8d <= {bus.o_bcd8d[11:0], shreg[3:0]};
      else if (ok && (shreg == ASCII_CLR_U || shreg == ASCII_CLR_L)) bus.o_bcd8d <= '0;
    end
endmodule

// File: tb/tb_uart_rx_bcd.sv
// tb_uart_rx_bcd: directed 8N1 frames against uart_rx_bcd at 160 clocks per bit.
module tb_uart_rx_bcd;
  localparam int BIT = 160;
  logic clk = 1'b0;
  logic rstn = 1'b0;
  int n_chk = 0;
  int n_fail = 0;
  int n_valid = 0;
  int n_err = 0;
  bit both_seen = 1'b0;
  bit led_seen;
  uart_rx_bcd_if bus ();
  uart_rx_bcd #(.CLK_FREQ(1_600_000), .BAUD(10_000)) dut (
    .i_clk(clk), .i_rstn(rstn), .bus(bus.slave)
  );
  always #5 clk = ~clk;
  always @(negedge clk) begin
    if (bus.o_rx_valid) n_valid++;
    if (bus.o_frame_err) n_err++;
    if (bus.o_rx_valid && bus.o_frame_err) both_seen = 1'b1;
  end
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic hold(input logic v, input int n);
    @(negedge clk);
    bus.i_rx_data = v;
    repeat (n - 1) @(negedge clk);
  endtask
  // A bad frame keeps the stop bit low only past its mid-sample so the resync start aborts cleanly.
  task automatic send(input logic [7:0] b, input bit good);
    hold(1'b0, BIT);
    for (int i = 0; i < 8; i++) hold(b[i], BIT);
    if (good) hold(1'b1, BIT);
    else begin
      hold(1'b0, 100);
      hold(1'b1, 60);
    end
    hold(1'b1, 40);
  endtask
  initial begin
    int v0, e0;
    bus.i_rx_data = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    chk("rst_byte", 32'(bus.o_rx_byte), 32'h0);
    chk("rst_valid", 32'(bus.o_rx_valid), 32'h0);
    chk("rst_err", 32'(bus.o_frame_err), 32'h0);
    chk("rst_bcd", 32'(bus.o_bcd8d), 32'h0);
    chk("rst_led", 32'(bus.o_led_rx), 32'h0);
    @(negedge clk);
    bus.i_rx_data = 1'b1;
    rstn = 1'b1;
    repeat (10) @(negedge clk);
    chk("idle_led", 32'(bus.o_led_rx), 32'h0);
    send(8'h31, 1'b1);
    chk("bcd_1", 32'(bus.o_bcd8d), 32'h0001);
    send(8'h32, 1'b1);
    send(8'h33, 1'b1);
    send(8'h34, 1'b1);
    send(8'h35, 1'b1);
    chk("valid_5", n_valid, 5);
    chk("byte_35", 32'(bus.o_rx_byte), 32'h35);
    chk("bcd_2345", 32'(bus.o_bcd8d), 32'h2345);
    chk("no_err_digits", n_err, 0);
    send(8'h41, 1'b1);
    chk("valid_A", n_valid, 6);
    chk("byte_A", 32'(bus.o_rx_byte), 32'h41);
    chk("bcd_after_A", 32'(bus.o_bcd8d), 32'h2345);
    send(8'h63, 1'b1);
    chk("byte_c", 32'(bus.o_rx_byte), 32'h63);
    chk("bcd_clr", 32'(bus.o_bcd8d), 32'h0000);
    send(8'h37, 1'b0);
    repeat (300) @(negedge clk);
    chk("err_cnt", n_err, 1);
    chk("valid_bad", n_valid, 7);
    chk("byte_bad", 32'(bus.o_rx_byte), 32'h63);
    chk("bcd_bad", 32'(bus.o_bcd8d), 32'h0000);
    chk("led_after_bad", 32'(bus.o_led_rx), 32'h0);
    v0 = n_valid;
    e0 = n_err;
    led_seen = 1'b0;
    @(negedge clk);
    bus.i_rx_data = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus.o_led_rx) led_seen = 1'b1;
    end
    bus.i_rx_data = 1'b1;
    repeat (300) @(negedge clk);
    chk("glitch_led_seen", 32'(led_seen), 32'h1);
    chk("glitch_led_off", 32'(bus.o_led_rx), 32'h0);
    chk("glitch_valid", n_valid, v0);
    chk("glitch_err", n_err, e0);
    send(8'h39, 1'b1);
    chk("valid_9", n_valid, v0 + 1);
    chk("byte_9", 32'(bus.o_rx_byte), 32'h39);
    chk("bcd_9", 32'(bus.o_bcd8d), 32'h0009);
    v0 = n_valid;
    hold(1'b0, BIT);
    for (int i = 0; i < 4; i++) hold(i == 3, BIT);
    rstn = 1'b0;
    bus.i_rx_data = 1'b1;
    repeat (4) @(negedge clk);
    rstn = 1'b1;
    repeat (2 * BIT) @(negedge clk);
    chk("abort_valid", n_valid, v0);
    chk("abort_err", n_err, e0);
    chk("abort_bcd", 32'(bus.o_bcd8d), 32'h0);
    send(8'h38, 1'b1);
    chk("valid_8", n_valid, v0 + 1);
    chk("byte_8", 32'(bus.o_rx_byte), 32'h38);
    chk("bcd_8", 32'(bus.o_bcd8d), 32'h0008);
    chk("never_both", 32'(both_seen), 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
